// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI responder.
package spi_resp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SPI_WIDTH_DEF = 16;
  localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/spi_resp_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus an edge register
// that yields single-cycle rise/fall strobes on the synchronized level.
module sync_edge
  import spi_resp_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;

  // Shift the pin through the synchronizer and keep one older copy for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
      edge_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      edge_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_reg[SYNC_STAGES-1];
  assign rise = sync_reg[SYNC_STAGES-1] & ~edge_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & edge_reg;

endmodule

// File: rtl/spi_resp.sv
// Word-wide SPI mode-0 responder: receives a WIDTH-bit word on MOSI while
// shifting a word captured at frame start out on MISO, MSB first.
module spi_resp
  import spi_resp_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCLK,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             frame_err,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  logic sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl;

  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(SCLK), .lvl(), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .din(SS_n), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(MOSI), .lvl(mosi_lvl), .rise(), .fall()
  );

  state_t           state_reg, state_next;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic [WIDTH-1:0] rx_shift_reg;
  logic [1:0]       warm_cnt_reg;
  logic             armed_reg;
  logic             frame_start, frame_stop;

  // A fall is only trusted after SS_n has been seen high with a settled
  // synchronizer, so a frame already running at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt_reg <= 2'd0;
      armed_reg    <= 1'b0;
    end else begin
      if (warm_cnt_reg != 2'd3) warm_cnt_reg <= warm_cnt_reg + 2'd1;
      if (warm_cnt_reg == 2'd3 && ss_lvl) armed_reg <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: frame opens on an armed SS_n fall, closes on SS_n rise.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ss_fall && armed_reg) state_next = SHIFT;
      SHIFT:   if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign frame_start = (state_reg == IDLE) && (state_next == SHIFT);
  assign frame_stop  = (state_reg == SHIFT) && ss_rise;

  // Outputs decoded from state; MISO is driven low whenever no frame is open.
  always_comb begin
    busy = (state_reg == SHIFT);
    MISO = (state_reg == SHIFT) ? tx_shift_reg[WIDTH-1] : 1'b0;
  end

  // Shift registers, bit counter and end-of-frame reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data      <= '0;
      rdy          <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      if (frame_start) begin
        tx_shift_reg <= tx_data;
        bit_cnt_reg  <= '0;
      end else if (frame_stop) begin
        if (bit_cnt_reg == CNT_FULL) begin
          rx_data <= rx_shift_reg;
          rdy     <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (state_reg == SHIFT) begin
        if (sclk_rise) begin
          rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], mosi_lvl};
          if (bit_cnt_reg != CNT_MAX) bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        // A fall before the first rise would otherwise lose the MSB.
        if (sclk_fall && bit_cnt_reg != '0)
          tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
